// File: rtl/register_seq_pkg.sv
// rtl/register_seq_pkg.sv - opcodes, FSM states and one-bit shift rule for register_seq_ext
package register_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_CLR = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef struct packed {
        logic right;
        logic in_bit;
        logic out_bit;
    } step_bits_t;

    // Width-independent: only the end bits of the register decide direction, entry and exit bit.
    function automatic step_bits_t shift_bits(input logic [3:0] op, input logic lsb,
                                              input logic msb, input logic fill);
        step_bits_t b;
        b.right   = 1'b0;
        b.in_bit  = fill;
        b.out_bit = msb;
        case (op)
            OP_SHR: begin b.right = 1'b1; b.in_bit = fill; b.out_bit = lsb; end
            OP_ROR: begin b.right = 1'b1; b.in_bit = lsb;  b.out_bit = lsb; end
            OP_ASR: begin b.right = 1'b1; b.in_bit = msb;  b.out_bit = lsb; end
            OP_ROL: begin b.right = 1'b0; b.in_bit = msb;  b.out_bit = msb; end
            default: begin b.right = 1'b0; b.in_bit = fill; b.out_bit = msb; end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/register_seq_ext_if.sv
// rtl/register_seq_ext_if.sv - op request and register status bundle for register_seq_ext
interface register_seq_ext_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AW         = $clog2(DATA_WIDTH + 1)
);
    logic                  op_valid;
    logic                  op_ready;
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] in;
    logic [AW-1:0]         amount;
    logic                  fill;
    logic                  abort;
    logic [DATA_WIDTH-1:0] out;
    logic                  carry;
    logic                  zero;
    logic                  busy;
    logic                  done;

    modport master (
        output op_valid, op, in, amount, fill, abort,
        input  op_ready, out, carry, zero, busy, done
    );

    modport slave (
        input  op_valid, op, in, amount, fill, abort,
        output op_ready, out, carry, zero, busy, done
    );
endinterface

// File: rtl/register_seq_ext_shift_step.sv
// rtl/register_seq_ext_shift_step.sv - combinational single-bit shifter used on every SHIFT cycle
import register_seq_pkg::*;

module shift_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] value_i,
    input  logic [3:0]   mode_i,
    input  logic         fill_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);
    step_bits_t b;

    always_comb begin
        b       = shift_bits(mode_i, value_i[0], value_i[W-1], fill_i);
        value_o = b.right ? {b.in_bit, value_i[W-1:1]} : {value_i[W-2:0], b.in_bit};
        carry_o = b.out_bit;
    end
endmodule

// File: rtl/register_seq_ext.sv
// rtl/register_seq_ext.sv - datapath register with handshaked opcodes and serial shift/rotate FSM
import register_seq_pkg::*;

module register_seq_ext #(
    parameter int DATA_WIDTH = 16,
    parameter int SATURATE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    register_seq_ext_if.slave bus
);
    localparam int AW = $clog2(DATA_WIDTH + 1);
    localparam logic [AW-1:0]         DW_AW   = AW'(DATA_WIDTH);
    localparam logic [AW-1:0]         ONE_AW  = AW'(1);
    localparam logic [DATA_WIDTH-1:0] MAX_VAL = {DATA_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  carry_q, carry_d;
    logic                  done_q, done_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [3:0]            sop_q, sop_d;
    logic                  fill_q, fill_d;

    logic [AW-1:0]         amt;
    logic [DATA_WIDTH-1:0] step_val;
    logic                  step_carry;

    shift_step #(.W(DATA_WIDTH)) u_step (
        .value_i (out_q),
        .mode_i  (sop_q),
        .fill_i  (fill_q),
        .value_o (step_val),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        sop_d   = sop_q;
        fill_d  = fill_q;
        amt     = (bus.amount > DW_AW) ? DW_AW : bus.amount;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    done_d = 1'b1;
                    case (bus.op)
                        OP_CLR: begin out_d = '0; carry_d = 1'b0; end
                        OP_LD:  out_d = bus.in;
                        OP_INC: begin
                            carry_d = (out_q == MAX_VAL);
                            if (out_q == MAX_VAL) out_d = (SATURATE != 0) ? MAX_VAL : '0;
                            else                  out_d = out_q + 1'b1;
                        end
                        OP_DEC: begin
                            carry_d = (out_q == '0);
                            if (out_q == '0) out_d = (SATURATE != 0) ? '0 : MAX_VAL;
                            else             out_d = out_q - 1'b1;
                        end
                        OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: begin
                            // A zero-length shift completes like a single-cycle op.
                            if (amt != '0) begin
                                done_d  = 1'b0;
                                state_d = ST_SHIFT;
                                cnt_d   = amt;
                                sop_d   = bus.op;
                                fill_d  = bus.fill;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    out_d   = step_val;
                    carry_d = step_carry;
                    cnt_d   = cnt_q - ONE_AW;
                    if (cnt_q == ONE_AW) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            sop_q   <= OP_NOP;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            sop_q   <= sop_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.op_ready = (state_q == ST_IDLE);
    assign bus.busy     = (state_q == ST_SHIFT);
    assign bus.out      = out_q;
    assign bus.carry    = carry_q;
    assign bus.zero     = (out_q == '0);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_register_seq_ext.sv
// tb/tb_register_seq_ext.sv - directed self-checking bench for wrapping and saturating register_seq_ext
module tb_register_seq_ext;
    import register_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    register_seq_ext_if #(.DATA_WIDTH(16)) bus0 ();
    register_seq_ext_if #(.DATA_WIDTH(16)) bus1 ();

    register_seq_ext #(.DATA_WIDTH(16), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    register_seq_ext #(.DATA_WIDTH(16), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [3:0] o, input logic [15:0] d,
                          input logic [4:0] a, input logic f);
        bus0.op_valid = v; bus0.op = o; bus0.in = d; bus0.amount = a; bus0.fill = f;
        bus1.op_valid = v; bus1.op = o; bus1.in = d; bus1.amount = a; bus1.fill = f;
    endtask

    task automatic set_abort(input logic ab);
        bus0.abort = ab;
        bus1.abort = ab;
    endtask

    // Presents one op at a negedge, returns 1 time unit after its accept edge.
    task automatic do_op(input logic [3:0] o, input logic [15:0] d, input logic [4:0] a, input logic f);
        @(negedge clk);
        set_in(1'b1, o, d, a, f);
        @(posedge clk);
        #1;
        set_in(1'b0, OP_NOP, 16'h0, 5'd0, 1'b0);
    endtask

    // Counts edges after accept until done is seen, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus0.done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        set_in(1'b0, OP_NOP, 16'h0, 5'd0, 1'b0);
        set_abort(1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.out !== 16'h0) begin errors++; $display("FAIL reset_out got %h want 0000", bus0.out); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", bus0.carry); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus0.done); end
        checks++; if (bus0.zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", bus0.zero); end
        checks++; if (bus0.op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus0.op_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_clr;
        do_op(OP_LD, 16'h8001, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'h8001) begin errors++; $display("FAIL ld_out got %h want 8001", bus0.out); end
        checks++; if (bus0.zero !== 1'b0) begin errors++; $display("FAIL ld_zero got %b want 0", bus0.zero); end
        checks++; if (bus0.done !== 1'b1) begin errors++; $display("FAIL ld_done got %b want 1", bus0.done); end
        @(posedge clk); #1;
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL ld_done_pulse got %b want 0", bus0.done); end
        do_op(OP_CLR, 16'h0, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'h0) begin errors++; $display("FAIL clr_out got %h want 0000", bus0.out); end
        checks++; if (bus0.zero !== 1'b1) begin errors++; $display("FAIL clr_zero got %b want 1", bus0.zero); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL clr_carry got %b want 0", bus0.carry); end
    endtask

    task automatic test_inc_dec;
        do_op(OP_LD, 16'hFFFF, 5'd0, 1'b0);
        do_op(OP_INC, 16'h0, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'h0000) begin errors++; $display("FAIL inc_wrap_out got %h want 0000", bus0.out); end
        checks++; if (bus0.carry !== 1'b1) begin errors++; $display("FAIL inc_wrap_carry got %b want 1", bus0.carry); end
        checks++; if (bus1.out !== 16'hFFFF) begin errors++; $display("FAIL inc_sat_out got %h want ffff", bus1.out); end
        checks++; if (bus1.carry !== 1'b1) begin errors++; $display("FAIL inc_sat_carry got %b want 1", bus1.carry); end
        do_op(OP_LD, 16'h0000, 5'd0, 1'b0);
        do_op(OP_DEC, 16'h0, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'hFFFF) begin errors++; $display("FAIL dec_wrap_out got %h want ffff", bus0.out); end
        checks++; if (bus0.carry !== 1'b1) begin errors++; $display("FAIL dec_wrap_carry got %b want 1", bus0.carry); end
        checks++; if (bus1.out !== 16'h0000) begin errors++; $display("FAIL dec_sat_out got %h want 0000", bus1.out); end
        checks++; if (bus1.carry !== 1'b1) begin errors++; $display("FAIL dec_sat_carry got %b want 1", bus1.carry); end
        do_op(OP_LD, 16'h0010, 5'd0, 1'b0);
        do_op(OP_INC, 16'h0, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'h0011) begin errors++; $display("FAIL inc_plain_out got %h want 0011", bus0.out); end
        checks++; if (bus1.carry !== 1'b0) begin errors++; $display("FAIL inc_plain_carry got %b want 0", bus1.carry); end
        do_op(OP_DEC, 16'h0, 5'd0, 1'b0);
        checks++; if (bus1.out !== 16'h0010) begin errors++; $display("FAIL dec_plain_out got %h want 0010", bus1.out); end
    endtask

    task automatic test_shifts;
        int cyc;
        do_op(OP_LD, 16'h8001, 5'd0, 1'b0);
        do_op(OP_ROR, 16'h0, 5'd4, 1'b0);
        checks++; if (bus0.op_ready !== 1'b0 || bus0.busy !== 1'b1) begin errors++;
            $display("FAIL ror_busy got ready=%b busy=%b want ready=0 busy=1", bus0.op_ready, bus0.busy); end
        wait_done(cyc);
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ror_latency got %0d want 4", cyc); end
        checks++; if (bus0.out !== 16'h1800) begin errors++; $display("FAIL ror_out got %h want 1800", bus0.out); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL ror_carry got %b want 0", bus0.carry); end
        checks++; if (bus0.op_ready !== 1'b1) begin errors++; $display("FAIL ror_ready_end got %b want 1", bus0.op_ready); end

        do_op(OP_LD, 16'h8001, 5'd0, 1'b0);
        do_op(OP_ASR, 16'h0, 5'd3, 1'b0);
        wait_done(cyc);
        checks++; if (cyc !== 3) begin errors++; $display("FAIL asr_latency got %0d want 3", cyc); end
        checks++; if (bus0.out !== 16'hF000) begin errors++; $display("FAIL asr_out got %h want f000", bus0.out); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL asr_carry got %b want 0", bus0.carry); end

        do_op(OP_LD, 16'h1234, 5'd0, 1'b0);
        do_op(OP_SHL, 16'h0, 5'd20, 1'b1);
        wait_done(cyc);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL shl_clamp_latency got %0d want 16", cyc); end
        checks++; if (bus0.out !== 16'hFFFF) begin errors++; $display("FAIL shl_clamp_out got %h want ffff", bus0.out); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL shl_clamp_carry got %b want 0", bus0.carry); end

        do_op(OP_LD, 16'h4003, 5'd0, 1'b0);
        do_op(OP_ROL, 16'h0, 5'd2, 1'b0);
        wait_done(cyc);
        checks++; if (bus0.out !== 16'h000D || bus0.carry !== 1'b1) begin errors++;
            $display("FAIL rol_out got %h/%b want 000d/1", bus0.out, bus0.carry); end

        do_op(OP_SHR, 16'h0, 5'd0, 1'b1);
        checks++; if (bus0.done !== 1'b1 || bus0.out !== 16'h000D || bus0.busy !== 1'b0) begin errors++;
            $display("FAIL shr_zero_amt got done=%b out=%h busy=%b want 1/000d/0", bus0.done, bus0.out, bus0.busy); end
    endtask

    task automatic test_abort;
        bit saw_done;
        do_op(OP_LD, 16'h00F0, 5'd0, 1'b0);
        do_op(OP_SHR, 16'h0, 5'd8, 1'b0);
        saw_done = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (bus0.done === 1'b1) saw_done = 1'b1; end
        set_abort(1'b1);
        @(posedge clk); #1;
        set_abort(1'b0);
        if (bus0.done === 1'b1) saw_done = 1'b1;
        checks++; if (bus0.out !== 16'h001E) begin errors++; $display("FAIL abort_out got %h want 001e", bus0.out); end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", saw_done); end
        checks++; if (bus0.op_ready !== 1'b1 || bus0.busy !== 1'b0) begin errors++;
            $display("FAIL abort_idle got ready=%b busy=%b want 1/0", bus0.op_ready, bus0.busy); end
        checks++; if (bus0.carry !== 1'b0) begin errors++; $display("FAIL abort_carry got %b want 0", bus0.carry); end
        do_op(OP_LD, 16'h5A5A, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'h5A5A) begin errors++; $display("FAIL abort_reload got %h want 5a5a", bus0.out); end
    endtask

    task automatic test_back_to_back;
        do_op(OP_LD, 16'h0001, 5'd0, 1'b0);
        do_op(OP_SHL, 16'h0, 5'd2, 1'b0);
        set_in(1'b1, OP_LD, 16'hBEEF, 5'd0, 1'b0);
        @(posedge clk); #1;
        checks++; if (bus0.out !== 16'h0002) begin errors++; $display("FAIL hold_mid got %h want 0002", bus0.out); end
        @(posedge clk); #1;
        checks++; if (bus0.out !== 16'h0004 || bus0.done !== 1'b1 || bus0.op_ready !== 1'b1) begin errors++;
            $display("FAIL hold_end got out=%h done=%b ready=%b want 0004/1/1", bus0.out, bus0.done, bus0.op_ready); end
        @(posedge clk); #1;
        set_in(1'b0, OP_NOP, 16'h0, 5'd0, 1'b0);
        checks++; if (bus0.out !== 16'hBEEF) begin errors++; $display("FAIL hold_accept got %h want beef", bus0.out); end
    endtask

    task automatic test_reset_mid_shift;
        do_op(OP_LD, 16'hFFFF, 5'd0, 1'b0);
        do_op(OP_SHR, 16'h0, 5'd8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus0.out !== 16'h0 || bus0.busy !== 1'b0 || bus0.op_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid got out=%h busy=%b ready=%b want 0000/0/1", bus0.out, bus0.busy, bus0.op_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.out !== 16'h0 || bus0.done !== 1'b0) begin errors++;
            $display("FAIL rst_discard got out=%h done=%b want 0000/0", bus0.out, bus0.done); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_clr();
        test_inc_dec();
        test_shifts();
        test_abort();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
